// File: rtl/pool_fifo_multi_if.sv
// Handshake and buffer-status bundle between the conv-stage producer, the pooling FIFO
// and the downstream serializer.
interface pool_fifo_multi_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CH     = 4,
  parameter int unsigned DEPTH  = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                   clr;
  logic                   mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*4*DATA_W-1:0] din;
  logic                   rd_en;
  logic [CH*DATA_W-1:0]   dout;
  logic                   dout_valid;
  logic [AW:0]            count;
  logic                   empty;
  logic                   full;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clr, mode, in_valid, din, rd_en,
    input  in_ready, dout, dout_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  clr, mode, in_valid, din, rd_en,
    output in_ready, dout, dout_valid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pool_fifo_multi.sv
// 2x2 max/average pooling over CH channels with optional ReLU, feeding a circular buffer
// drained by rd_en. Two-stage reduce pipeline; in-flight beats reserve buffer space.
module pool_fifo_multi #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CH     = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RELU   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  pool_fifo_multi_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = AW + 2;
  localparam int unsigned WW = CH * DATA_W;

  // Pairwise stage result: DATA_W+1 bits holds either a pair sum or a sign-extended max.
  function automatic logic signed [DATA_W:0] reduce_pair(
    input logic md, input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] ae, be;
    ae = {a[DATA_W-1], a};
    be = {b[DATA_W-1], b};
    if (md) reduce_pair = ae + be;
    else    reduce_pair = (be > ae) ? be : ae;
  endfunction

  function automatic logic [DATA_W-1:0] reduce_final(
    input logic md, input logic signed [DATA_W:0] a, input logic signed [DATA_W:0] b);
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W+1:0] avg;
    logic        [DATA_W-1:0] r;
    sum = {a[DATA_W], a} + {b[DATA_W], b};
    avg = sum >>> 2;
    if (md) r = avg[DATA_W-1:0];
    else    r = (b > a) ? b[DATA_W-1:0] : a[DATA_W-1:0];
    if ((RELU != 0) && r[DATA_W-1]) r = '0;
    reduce_final = r;
  endfunction

  logic [CH-1:0][DATA_W:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                      s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [CH-1:0][DATA_W-1:0] s2_data_q, s2_data_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [WW-1:0]             dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic                      empty_q, empty_d, full_q, full_d;
  logic                      overflow_q, overflow_d, underflow_q, underflow_d;
  logic                      accept, commit, pop;
  logic [OW-1:0]             occ;
  logic [WW-1:0]             mem_q [DEPTH];

  always_comb begin
    s1_valid_d   = 1'b0;
    s1_mode_d    = s1_mode_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s2_valid_d   = 1'b0;
    s2_data_d    = s2_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    accept       = 1'b0;
    commit       = 1'b0;
    pop          = 1'b0;

    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      accept = bus.in_valid & in_ready_q;
      commit = s2_valid_q;
      pop    = bus.rd_en & (count_q != '0);
      if (bus.in_valid & ~in_ready_q)   overflow_d  = 1'b1;
      if (bus.rd_en & (count_q == '0)) underflow_d = 1'b1;

      s1_valid_d = accept;
      if (accept) begin
        s1_mode_d = bus.mode;
        for (int c = 0; c < int'(CH); c++) begin
          s1_a_d[c] = reduce_pair(bus.mode, bus.din[(4*c+0)*DATA_W +: DATA_W],
                                            bus.din[(4*c+1)*DATA_W +: DATA_W]);
          s1_b_d[c] = reduce_pair(bus.mode, bus.din[(4*c+2)*DATA_W +: DATA_W],
                                            bus.din[(4*c+3)*DATA_W +: DATA_W]);
        end
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int c = 0; c < int'(CH); c++) begin
          s2_data_d[c] = reduce_final(s1_mode_q, s1_a_q[c], s1_b_q[c]);
        end
      end

      if (commit) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      dout_valid_d = pop;
      count_d      = count_q + CW'(commit) - CW'(pop);
    end

    // Status flags are registered from next-state so they track count exactly.
    occ        = OW'(count_d) + OW'(s1_valid_d) + OW'(s2_valid_d);
    in_ready_d = occ < OW'(DEPTH);
    empty_d    = count_d == '0;
    full_d     = count_d == CW'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      in_ready_q   <= in_ready_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= s2_data_q;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_pool_fifo_multi.sv
// Scoreboard bench for pool_fifo_multi: RELU=0 and RELU=1 instances share stimulus,
// expected words are queued at accept and checked by a monitor on each dout_valid.
module tb_pool_fifo_multi;
  localparam int unsigned DW    = 18;
  localparam int unsigned CH    = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WW    = CH * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pool_fifo_multi_if #(.DATA_W(DW), .CH(CH), .DEPTH(DEPTH)) b ();
  pool_fifo_multi_if #(.DATA_W(DW), .CH(CH), .DEPTH(DEPTH)) r ();

  assign r.clr      = b.clr;
  assign r.mode     = b.mode;
  assign r.in_valid = b.in_valid;
  assign r.din      = b.din;
  assign r.rd_en    = b.rd_en;

  pool_fifo_multi #(.DATA_W(DW), .CH(CH), .DEPTH(DEPTH), .RELU(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b));
  pool_fifo_multi #(.DATA_W(DW), .CH(CH), .DEPTH(DEPTH), .RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .bus(r));

  int tests = 0;
  int fails = 0;
  int tap [CH][4];
  logic [WW-1:0] bq [$];
  logic [WW-1:0] rq [$];
  logic [WW-1:0] last_b = '0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack4(input int a, input int bb, input int c, input int d);
    logic [WW-1:0] w;
    w = '0;
    w[0*DW +: DW] = DW'(a);
    w[1*DW +: DW] = DW'(bb);
    w[2*DW +: DW] = DW'(c);
    w[3*DW +: DW] = DW'(d);
    return w;
  endfunction

  function automatic logic [WW-1:0] model(input logic md, input bit relu);
    logic [WW-1:0] w;
    int v, s;
    w = '0;
    for (int c = 0; c < int'(CH); c++) begin
      if (md) begin
        s = tap[c][0] + tap[c][1] + tap[c][2] + tap[c][3];
        v = s >>> 2;
      end else begin
        v = tap[c][0];
        for (int t = 1; t < 4; t++) if (tap[c][t] > v) v = tap[c][t];
      end
      if (relu && v < 0) v = 0;
      w[c*DW +: DW] = DW'(v);
    end
    return w;
  endfunction

  function automatic logic [CH*4*DW-1:0] din_from_taps();
    logic [CH*4*DW-1:0] d;
    for (int c = 0; c < int'(CH); c++)
      for (int t = 0; t < 4; t++) d[(4*c+t)*DW +: DW] = DW'(tap[c][t]);
    return d;
  endfunction

  task automatic set_ch(input int c, input int t0, input int t1, input int t2, input int t3);
    tap[c][0] = t0; tap[c][1] = t1; tap[c][2] = t2; tap[c][3] = t3;
  endtask

  task automatic gen(input int i);
    for (int c = 0; c < int'(CH); c++) begin
      tap[c][0] = (i * 37 + c * 11) % 200 - 100;
      tap[c][1] = -((i * 13 + c) % 150);
      tap[c][2] = c * 1000 - i * 50;
      tap[c][3] = (i % 3 == 0) ? -131072 : i * 3;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input bit push);
    b.mode     = md;
    b.din      = din_from_taps();
    b.in_valid = 1'b1;
    if (push) begin
      bq.push_back(model(md, 1'b0));
      rq.push_back(model(md, 1'b1));
    end
  endtask

  // Scoreboard monitor: every dout_valid pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b.dout_valid) begin
        if (bq.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_unexpected: got %h expected no pop at %0t", b.dout, $time);
        end else begin
          last_b = bq.pop_front();
          chk("pop_data", b.dout, last_b);
        end
      end
      if (r.dout_valid) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL relu_pop_unexpected: got %h expected no pop at %0t", r.dout, $time);
        end else begin
          chk("relu_pop_data", r.dout, rq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b.clr = 1'b0; b.mode = 1'b0; b.in_valid = 1'b0; b.din = '0; b.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_count", WW'(b.count), '0);
    chk("rst_empty", WW'(b.empty), 1);
    chk("rst_in_ready", WW'(b.in_ready), 1);
    chk("rst_full", WW'(b.full), '0);
    chk("rst_dout", b.dout, '0);
    chk("rst_dout_valid", WW'(b.dout_valid), '0);
    chk("rst_flags", WW'({b.overflow, b.underflow}), '0);

    // Max pool with hand-computed results
    set_ch(0, 5, -3, 9, 2); set_ch(1, -7, -1, -4, -9);
    set_ch(2, 0, 0, 0, 0);  set_ch(3, 100, -100, 100, -100);
    drive(1'b0, 1'b0);
    bq.push_back(pack4(9, -1, 0, 100));
    rq.push_back(pack4(9, 0, 0, 100));
    step(); b.in_valid = 1'b0;
    chk("lat_edge_n", WW'(b.count), '0);
    step();
    chk("lat_edge_n1", WW'(b.count), '0);
    step();
    chk("lat_edge_n2", WW'(b.count), 1);
    chk("lat_empty", WW'(b.empty), '0);
    b.rd_en = 1'b1; step(); b.rd_en = 1'b0;
    step();
    chk("dout_valid_pulse", WW'(b.dout_valid), '0);

    // Average pool including full-scale extremes
    set_ch(0, 4, 5, 6, 7); set_ch(1, -1, -2, -2, -2);
    set_ch(2, -131072, -131072, -131072, -131072);
    set_ch(3, 131071, 131071, 131071, 131071);
    drive(1'b1, 1'b0);
    bq.push_back(pack4(5, -2, -131072, 131071));
    rq.push_back(pack4(5, 0, 0, 131071));
    step(); b.in_valid = 1'b0;
    repeat (2) step();
    chk("avg_count", WW'(b.count), 1);
    b.rd_en = 1'b1; step(); b.rd_en = 1'b0;
    step();

    // Fill past capacity with in_valid held
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      gen(i);
      chk("fill_in_ready", WW'(b.in_ready), WW'(i < int'(DEPTH)));
      drive(1'(i % 2), i < int'(DEPTH));
      step();
    end
    b.in_valid = 1'b0;
    repeat (2) step();
    chk("fill_count", WW'(b.count), WW'(DEPTH));
    chk("fill_full", WW'(b.full), 1);
    chk("fill_overflow", WW'(b.overflow), 1);
    chk("fill_in_ready_low", WW'(b.in_ready), '0);
    b.rd_en = 1'b1;
    repeat (DEPTH) step();
    b.rd_en = 1'b0;
    step();
    chk("drain_empty", WW'(b.empty), 1);
    chk("drain_in_ready", WW'(b.in_ready), 1);
    chk("drain_underflow", WW'(b.underflow), '0);

    // Interleaved push/pop of 40 beats across pointer wrap
    for (int i = 0; i < 40; i++) begin
      gen(i + 100);
      drive(1'(i % 3 == 0), 1'b1);
      b.rd_en = (i >= 4);
      step();
    end
    b.in_valid = 1'b0;
    b.rd_en = 1'b1;
    repeat (4) step();
    b.rd_en = 1'b0;
    step();
    chk("wrap_empty", WW'(b.empty), 1);
    chk("wrap_count", WW'(b.count), '0);
    chk("wrap_underflow", WW'(b.underflow), '0);

    // Concurrent commit and pop at count 3
    for (int i = 0; i < 3; i++) begin
      gen(i + 200); drive(1'b0, 1'b1); step();
    end
    b.in_valid = 1'b0;
    repeat (2) step();
    chk("conc_pre_count", WW'(b.count), 3);
    gen(300); drive(1'b1, 1'b1); step();
    b.in_valid = 1'b0; step();
    b.rd_en = 1'b1; step(); b.rd_en = 1'b0;
    chk("conc_count", WW'(b.count), 3);
    b.rd_en = 1'b1; repeat (3) step(); b.rd_en = 1'b0;
    step();
    chk("conc_drained", WW'(b.count), '0);
    b.rd_en = 1'b1; step(); b.rd_en = 1'b0;
    chk("underflow_set", WW'(b.underflow), 1);
    chk("underflow_dout_valid", WW'(b.dout_valid), '0);
    chk("underflow_dout_hold", b.dout, last_b);

    // Pop at count 0 while a commit lands: no bypass
    gen(301); drive(1'b0, 1'b1); step();
    b.in_valid = 1'b0; step();
    b.rd_en = 1'b1; step(); b.rd_en = 1'b0;
    chk("nobypass_count", WW'(b.count), 1);
    chk("nobypass_dout_valid", WW'(b.dout_valid), '0);

    // Clear with count 10 and two beats in flight
    for (int i = 0; i < 9; i++) begin
      gen(i + 400); drive(1'b1, 1'b1); step();
    end
    b.in_valid = 1'b0;
    repeat (2) step();
    chk("clr_pre_count", WW'(b.count), 10);
    gen(500); drive(1'b0, 1'b0); step();
    gen(501); drive(1'b1, 1'b0); step();
    b.clr = 1'b1;
    step();
    b.clr = 1'b0; b.in_valid = 1'b0;
    bq.delete(); rq.delete();
    chk("clr_count", WW'(b.count), '0);
    chk("clr_empty", WW'(b.empty), 1);
    chk("clr_flags", WW'({b.overflow, b.underflow}), '0);
    chk("clr_dout_valid", WW'(b.dout_valid), '0);
    chk("clr_in_ready", WW'(b.in_ready), 1);
    repeat (4) step();
    chk("clr_inflight_gone", WW'(b.count), '0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      gen(i + 600); drive(1'b0, 1'b0); step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", WW'(b.count), '0);
    chk("arst_empty", WW'(b.empty), 1);
    chk("arst_in_ready", WW'(b.in_ready), 1);
    chk("arst_dout", b.dout, '0);
    chk("arst_full_flags", WW'({b.full, b.overflow, b.underflow, b.dout_valid}), '0);
    b.in_valid = 1'b0;
    bq.delete(); rq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) step();
    chk("arst_inflight_lost", WW'(b.count), '0);
    chk("sb_drained", WW'(bq.size() + rq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
